nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_pkg.sv | 15 +
 rtl/nibble_packer_if.sv | 29 ++
 rtl/barrel_shifter.sv | 17 +
 rtl/nibble_packer.sv | 69 ++++++
 tb/tb_nibble_packer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble packer: nibble width, FSM encoding and
// the count-width helper used by the packer and its interface.
package nibble_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  // Count must hold the value n itself, hence the extra bit.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/nibble_packer_if.sv
// Nibble-in / packed-word-out handshake bundle between an upstream nibble
// source, the packer and the downstream word consumer.
interface nibble_packer_if
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int CW = cnt_w(NIBBLES);

  logic [NIBBLE_W-1:0]         in_data;
  logic                        in_valid;
  logic                        in_ready;
  logic                        flush;
  logic [NIBBLE_W*NIBBLES-1:0] out_data;
  logic [CW-1:0]               out_count;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_count, out_valid
  );

endinterface

// File: rtl/barrel_shifter.sv
// 4-bit rotator feeding the packer: dir_i=0 rotates left, dir_i=1 rotates right.
module barrel_shifter (
  input  logic [3:0] d_i,
  input  logic [1:0] s_i,
  input  logic       dir_i,
  output logic [3:0] y_o
);
  logic [7:0] dbl;
  logic [7:0] rot_l;
  logic [7:0] rot_r;

  assign dbl   = {d_i, d_i};
  assign rot_l = dbl << s_i;
  assign rot_r = dbl >> s_i;
  assign y_o   = dir_i ? rot_r[3:0] : rot_l[7:4];

endmodule

// File: rtl/nibble_packer.sv
// Packs a stream of nibbles LSB-first into NIBBLES-wide words; a word is
// presented when full or when flush closes a non-empty partial word.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 4
)(
  input  logic          clk,
  input  logic          rst,
  nibble_packer_if.slave bus
);
  localparam int CW = cnt_w(NIBBLES);
  localparam int DW = NIBBLE_W * NIBBLES;

  logic [0:0]         state_q, state_d;
  logic [DW-1:0]      buf_q, buf_d, filled;
  logic [CW-1:0]      count_q, count_d, count_inc;
  logic [NIBBLES-1:0] slot_we;
  logic               accept;
  logic               last;

  assign bus.in_ready = (state_q == ST_FILL) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign count_inc    = count_q + CW'(accept);
  assign last         = accept && (count_q == CW'(NIBBLES - 1));

  // The count doubles as the write pointer: slot k takes the k-th nibble.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_slot
    assign slot_we[gi] = accept && (count_q == CW'(gi));
    assign filled[gi*NIBBLE_W +: NIBBLE_W] =
      slot_we[gi] ? bus.in_data : buf_q[gi*NIBBLE_W +: NIBBLE_W];
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    count_d = count_q;
    if (state_q == ST_FILL) begin
      buf_d   = filled;
      count_d = count_inc;
      // A flush only closes a word that holds at least one nibble,
      // counting one accepted on the same edge.
      if (last || (bus.flush && (count_inc != '0))) begin
        state_d = ST_FULL;
      end
    end else if (bus.out_ready) begin
      state_d = ST_FILL;
      buf_d   = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  assign bus.out_data  = buf_q;
  assign bus.out_count = count_q;
  assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer with a word-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_nibble_packer;
  import nibble_pkg::*;

  localparam int N  = 4;
  localparam int CW = cnt_w(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_packer_if #(.NIBBLES(N)) bus ();

  logic [3:0] tb_data = 4'h0;
  logic [3:0] bs_d    = 4'h0;
  logic [1:0] bs_s    = 2'd0;
  logic       bs_dir  = 1'b0;
  logic       use_bs  = 1'b0;
  logic [3:0] bs_y;

  barrel_shifter u_bs (
    .d_i   (bs_d),
    .s_i   (bs_s),
    .dir_i (bs_dir),
    .y_o   (bs_y)
  );

  assign bus.in_data = use_bs ? bs_y : tb_data;

  nibble_packer #(.NIBBLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: the list of nibbles of the word being built and whether
  // a word is currently being presented.
  bit         mdl_live = 1'b0;
  bit         mdl_full = 1'b0;
  int         mdl_n    = 0;
  logic [3:0] mdl_nib[8];

  function automatic logic [31:0] mdl_word();
    logic [31:0] w = 32'h0;
    for (int k = 0; k < mdl_n; k++) w += 32'(mdl_nib[k]) << (4 * k);
    return w;
  endfunction

  // At each falling edge: check outputs produced by the last rising edge,
  // then advance the model with the inputs the next rising edge will see.
  always @(negedge clk) begin
    if (mdl_live) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mdl_full));
      chk("in_ready", 32'(bus.in_ready), 32'(!mdl_full && !rst));
      if (mdl_full) begin
        chk("model_data", 32'(bus.out_data), mdl_word());
        chk("model_count", 32'(bus.out_count), 32'(mdl_n));
        if (bus.out_ready && !rst)
          $display("[TB] word consumed data=%h count=%0d", bus.out_data, bus.out_count);
      end
    end
    if (rst) begin
      mdl_full = 1'b0;
      mdl_n    = 0;
      mdl_live = 1'b1;
    end else if (mdl_full) begin
      if (bus.out_ready) begin
        mdl_full = 1'b0;
        mdl_n    = 0;
      end
    end else begin
      if (bus.in_valid) begin
        mdl_nib[mdl_n] = bus.in_data;
        mdl_n++;
      end
      if (mdl_n == N || (bus.flush && mdl_n > 0)) mdl_full = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic fl);
    tb_data      = d;
    bus.in_valid = 1'b1;
    bus.flush    = fl;
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) step();

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_count", 32'(bus.out_count), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    rst = 1'b0;
    step();

    // Full word from left rotations of 1011
    send(4'hB, 1'b0); send(4'h7, 1'b0); send(4'hE, 1'b0); send(4'hD, 1'b0);
    @(negedge clk);
    chk("full_valid", 32'(bus.out_valid), 32'h1);
    chk("full_data", 32'(bus.out_data), 32'hDE7B);
    chk("full_count", 32'(bus.out_count), 32'h4);
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    step();
    @(negedge clk);
    chk("full_consumed", 32'(bus.out_valid), 32'h0);
    chk("full_ready_back", 32'(bus.in_ready), 32'h1);

    // Backpressure with garbage on the input
    bus.out_ready = 1'b0;
    send(4'hB, 1'b0); send(4'h7, 1'b0); send(4'hE, 1'b0); send(4'hD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tb_data      = 4'(4'hF - i);
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(negedge clk);
      chk("bp_data", 32'(bus.out_data), 32'hDE7B);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      step();
    end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_consumed", 32'(bus.out_valid), 32'h0);

    // Partial flush
    send(4'hA, 1'b0); send(4'h5, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("pflush_valid", 32'(bus.out_valid), 32'h1);
    chk("pflush_data", 32'(bus.out_data), 32'h005A);
    chk("pflush_count", 32'(bus.out_count), 32'h2);
    step();

    // Flush on the same edge as an accepted nibble
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b1);
    @(negedge clk);
    chk("aflush_data", 32'(bus.out_data), 32'h0321);
    chk("aflush_count", 32'(bus.out_count), 32'h3);
    step();

    // Flush on an empty word is ignored
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    chk("eflush_no_valid", 32'(bus.out_valid), 32'h0);
    step();
    @(negedge clk);
    chk("eflush_still_idle", 32'(bus.out_valid), 32'h0);

    // Mid-fill reset discards the partial word
    send(4'hF, 1'b0); send(4'hF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 32'(bus.out_valid), 32'h0);
    chk("mrst_data", 32'(bus.out_data), 32'h0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'h1);
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    @(negedge clk);
    chk("mrst_word", 32'(bus.out_data), 32'h4321);
    chk("mrst_count", 32'(bus.out_count), 32'h4);
    step();

    // Chained through the barrel shifter, right rotations of 1011
    use_bs = 1'b1;
    bs_d   = 4'b1011;
    bs_dir = 1'b1;
    for (int s = 0; s < 4; s++) begin
      bs_s         = 2'(s);
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("chain_data", 32'(bus.out_data), 32'h7EDB);
    chk("chain_count", 32'(bus.out_count), 32'h4);
    step();
    use_bs = 1'b0;

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
